// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine owning HI/LO; shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to let zero-operand multiplies and divide-by-zero skip the iteration phase.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] m;
    logic [2*WIDTH-1:0] acc, acc_init, mul_nx, div_nx, prod;
    logic [WIDTH:0] mul_sum, div_trial;
    logic is_div, neg_lo, neg_hi;
    logic a_neg, b_neg, div_zero, early;
    logic [WIDTH-1:0] a_mag, b_mag, dvd, q_fix, r_fix;
    assign a_neg    = ~op[0] & a[WIDTH-1];
    assign b_neg    = ~op[0] & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = op[1] & (b == '0);
    // A zero divisor leaves the dividend unsigned so the iterations return HI=a, LO=all ones.
    assign dvd      = div_zero ? a : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
    assign early    = div_zero | (~op[1] & ((a == '0) | (b == '0)));
    assign acc_init = early ? (div_zero ? {a, {WIDTH{1'b1}}} : '0)
                            : {{WIDTH{1'b0}}, op[1] ? dvd : b_mag};
`else
    assign early    = 1'b0;
    assign acc_init = {{WIDTH{1'b0}}, op[1] ? dvd : b_mag};
`endif
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    assign mul_nx    = {mul_sum, acc[WIDTH-1:1]};
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
    assign div_nx    = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod  = neg_lo ? -acc : acc;
    assign q_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign busy  = state != IDLE;
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? (early ? FIX : CALC) : IDLE;
            CALC:    state_nx = (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            m      <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= state == FIX;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        is_div <= op[1];
                        m      <= op[1] ? b_mag : a_mag;
                        acc    <= acc_init;
                        neg_lo <= ~div_zero & (a_neg ^ b_neg);
                        neg_hi <= ~div_zero & op[1] & a_neg;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_nx : mul_nx;
                end
                FIX: begin
                    hi <= is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
                    lo <= is_div ? q_fix : prod[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench; stimulus pushes expected HI/LO and done cycle, a monitor pops on done.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [1:0] op = '0;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    typedef struct { logic [31:0] hi; logic [31:0] lo; int cyc; } exp_t;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'd0) res = 64'(sx * sy);
        else if (o == 2'd1) res = {32'd0, x} * {32'd0, y};
        else if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
            q = sx / sy;
            r = sx % sy;
            res = {r[31:0], q[31:0]};
        end else begin
            q = longint'({32'd0, x}) / longint'({32'd0, y});
            r = longint'({32'd0, x}) % longint'({32'd0, y});
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            exp_t e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected: done at cycle %0d with hi=%h lo=%h, nothing outstanding", cyc, hi, lo);
            end else begin
                e = sb.pop_front();
                if (busy || hi !== e.hi || lo !== e.lo || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL result: got busy=%b hi=%h lo=%h cycle=%0d expected busy=0 hi=%h lo=%h cycle=%0d",
                             busy, hi, lo, cyc, e.hi, e.lo, e.cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, t);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int k);
        logic [63:0] r;
        wait_idle();
        r = model(o, x, y);
        sb.push_back('{hi: r[63:32], lo: r[31:0], cyc: cyc + 1 + 33});
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = cyc;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_outstanding", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, hi, lo}, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k);
        check("busy_first_cycle", 64'(busy), 64'd1);
        goto_cyc(k + 32);
        check("busy_last_cycle", 64'(busy), 64'd1);
        check("hold_hi_lo_busy", {hi, lo}, 64'd0);
        issue(2'd0, -32'sd3, 32'd7, k);
        issue(2'd2, -32'sd7, 32'd2, k);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, k);
        issue(2'd3, 32'd100, 32'd0, k);
        issue(2'd2, -32'sd100, 32'd0, k);
        drain();
        check("model_multu_max", model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);

        @(posedge clk); #1;
        wdata = 32'h1234_5678; mthi = 1'b1;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi_idle", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
        wdata = 32'hCAFE_BABE; mtlo = 1'b1;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_idle", {hi, lo}, {32'h1234_5678, 32'hCAFE_BABE});
        wdata = 32'h0BAD_F00D; mthi = 1'b1; mtlo = 1'b1; start = 1'b1; op = 2'd1; a = 32'd4; b = 32'd4;
        sb.push_back('{hi: 32'd0, lo: 32'd16, cyc: cyc + 1 + 33});
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_beats_move", {hi, lo}, {32'h1234_5678, 32'hCAFE_BABE});
        drain();

        issue(2'd1, 32'd5, 32'd6, k);
        goto_cyc(k + 10);
        op = 2'd3; a = 32'd9; b = 32'd2; start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        check("mthi_busy_ignored", 64'(hi), 64'd0);
        drain();
        repeat (40) @(posedge clk);
        #1;
        check("second_start_ignored", {hi, lo}, {32'd0, 32'd30});

        issue(2'd2, 32'd1000, 32'd7, k);
        goto_cyc(k + 10);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("async_reset_mid_op", {busy, done, hi, lo}, '0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        issue(2'd1, 32'd2, 32'd3, k);
        drain();

        for (int i = 0; i < 40; i++) issue(2'($urandom_range(0, 3)), pick(), pick(), k);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
